uart_bus_master: RTL and testbench

//  Host-side bus initiator: parses command frames from the UART RX byte stream, issues

---
 rtl/uart_bus_master_pkg.sv | 40 ++++
 rtl/uart_bus_master_resp_ser.sv | 75 +++++++
 rtl/uart_bus_master.sv | 203 ++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_bus_master_pkg                                             |
// | Brief    : Command/reply codes and state encodings for the UART bus master |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package uart_bus_master_pkg;

  // Command bytes accepted from the host
  localparam logic [7:0] c_CMD_READ     = 8'h52;  // 'R'
  localparam logic [3:0] c_CMD_WRITE_HI = 4'hA;   // write = 8'hA0 | byte_enables

  // Reply bytes returned to the host
  localparam logic [7:0] c_RSP_ACK      = 8'h4B;  // 'K', write done
  localparam logic [7:0] c_RSP_ERR      = 8'hEE;  // read timed out
  localparam logic [7:0] c_RSP_BADCMD   = 8'h3F;  // '?', unknown command

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_WAIT_RD = 3'd4,
    ST_SEND    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_WAIT  = 2'd1,
    SER_PULSE = 2'd2,
    SER_GUARD = 2'd3
  } ser_state_t;

  // A write command carries a non-zero byte-enable nibble under the 'A' prefix
  function automatic logic is_write_cmd(input logic [7:0] b);
    return (b[7:4] == c_CMD_WRITE_HI) && (b[3:0] != 4'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bus_master_resp_ser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_bus_master_resp_ser                                        |
// | Brief    : Reply serializer: sends 1..4 bytes MSB first over the UART TX   |
// |            byte port with a ready/strobe/guard handshake per byte          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_bus_master_resp_ser
  import uart_bus_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_count,
  input  logic [31:0] i_bytes,
  input  logic        i_tx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_we,
  output logic        o_done
);

  ser_state_t  r_state;
  ser_state_t  w_next;
  logic [31:0] r_sh;
  logic [2:0]  r_left;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SER_IDLE;
    else        r_state <= w_next;
  end

  // Byte shift register and remaining-byte count; shift once each byte is strobed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh   <= 32'h0;
      r_left <= 3'd0;
    end else if (i_start && (r_state == SER_IDLE)) begin
      r_sh   <= i_bytes;
      r_left <= i_count;
    end else if (r_state == SER_PULSE) begin
      r_sh   <= {r_sh[23:0], 8'h00};
      r_left <= r_left - 3'd1;
    end
  end

  // Handshake sequencing; the guard cycle skips the stale READY the UART still
  // shows right after a strobe
  always_comb begin
    w_next  = r_state;
    o_tx_we = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      SER_IDLE:  if (i_start) w_next = SER_WAIT;
      SER_WAIT:  if (i_tx_ready) w_next = SER_PULSE;
      SER_PULSE: begin
        o_tx_we = 1'b1;
        w_next  = SER_GUARD;
      end
      SER_GUARD: begin
        if (r_left == 3'd0) begin
          o_done = 1'b1;
          w_next = SER_IDLE;
        end else begin
          w_next = SER_WAIT;
        end
      end
      default:   w_next = SER_IDLE;
    endcase
  end

  assign o_tx_data = r_sh[31:24];

endmodule
`default_nettype wire

// File: rtl/uart_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_bus_master                                                 |
// | Brief    : Host-side bus initiator: decodes UART command frames, issues    |
// |            single-word bus reads/writes, returns replies over UART TX      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int MEM_SCALE    = 27,
  parameter int BYTE_TIMEOUT = 1000000,
  parameter int RESP_TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_we,
  input  logic                 tx_ready,
  output logic                 bus_req,
  input  logic                 bus_gnt,
  output logic [3:0]           oe,
  output logic [MEM_SCALE-1:0] addr,
  output logic [31:0]          wdata,
  output logic [3:0]           we,
  input  logic [31:0]          rdata,
  input  logic                 valid,
  output logic                 busy
);

  localparam int c_BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int c_RT_W = $clog2(RESP_TIMEOUT + 1);
  localparam logic [c_BT_W-1:0] c_BT_LAST = c_BT_W'(BYTE_TIMEOUT - 1);
  localparam logic [c_RT_W-1:0] c_RT_LAST = c_RT_W'(RESP_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_cnt;
  logic                 r_is_write;
  logic [3:0]           r_be;
  logic [MEM_SCALE-1:0] r_addr;
  logic [31:0]          r_wdata;
  logic [3:0]           r_we;
  logic [c_BT_W-1:0]    r_byte_tmr;
  logic [c_RT_W-1:0]    r_resp_tmr;

  logic                 w_cmd_ok;
  logic                 w_byte_to;
  logic                 w_resp_to;
  logic                 w_ser_start;
  logic [31:0]          w_ser_bytes;
  logic [2:0]           w_ser_count;
  logic                 w_ser_done;

  assign w_cmd_ok  = (rx_data == c_CMD_READ) || is_write_cmd(rx_data);
  assign w_byte_to = (r_byte_tmr == c_BT_LAST);
  assign w_resp_to = (r_resp_tmr == c_RT_LAST);

  // Main state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state, single-cycle bus strobe and serializer load requests
  always_comb begin
    w_next      = r_state;
    oe          = 4'h0;
    w_ser_start = 1'b0;
    w_ser_bytes = 32'h0;
    w_ser_count = 3'd1;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (w_cmd_ok) begin
            w_next = ST_ADDR;
          end else begin
            w_next      = ST_SEND;
            w_ser_start = 1'b1;
            w_ser_bytes = {c_RSP_BADCMD, 24'h0};
          end
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          if (r_cnt == 2'd3) w_next = r_is_write ? ST_DATA : ST_ISSUE;
        end else if (w_byte_to) begin
          w_next = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          if (r_cnt == 2'd3) w_next = ST_ISSUE;
        end else if (w_byte_to) begin
          w_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Leaving ISSUE on the grant cycle guarantees a single strobe per frame
        if (bus_gnt) begin
          oe = 4'hF;
          if (r_is_write) begin
            w_next      = ST_SEND;
            w_ser_start = 1'b1;
            w_ser_bytes = {c_RSP_ACK, 24'h0};
          end else begin
            w_next = ST_WAIT_RD;
          end
        end
      end
      ST_WAIT_RD: begin
        // Response data takes priority over a coincident timeout
        if (valid) begin
          w_next      = ST_SEND;
          w_ser_start = 1'b1;
          w_ser_bytes = rdata;
          w_ser_count = 3'd4;
        end else if (w_resp_to) begin
          w_next      = ST_SEND;
          w_ser_start = 1'b1;
          w_ser_bytes = {c_RSP_ERR, 24'h0};
        end
      end
      ST_SEND:  if (w_ser_done) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Frame capture: command flags, address/data shifting, byte-gap timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 2'd0;
      r_is_write <= 1'b0;
      r_be       <= 4'h0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_we       <= 4'h0;
      r_byte_tmr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt      <= 2'd0;
          r_byte_tmr <= '0;
          if (rx_valid) begin
            r_is_write <= is_write_cmd(rx_data);
            r_be       <= rx_data[3:0];
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            // Bytes shifted past the top of the bus address fall away unchecked
            r_addr     <= MEM_SCALE'({r_addr, rx_data});
            r_cnt      <= r_cnt + 2'd1;
            r_byte_tmr <= '0;
            if ((r_cnt == 2'd3) && !r_is_write) r_we <= 4'h0;
          end else begin
            r_byte_tmr <= r_byte_tmr + c_BT_W'(1);
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            r_wdata    <= {r_wdata[23:0], rx_data};
            r_cnt      <= r_cnt + 2'd1;
            r_byte_tmr <= '0;
            if (r_cnt == 2'd3) r_we <= r_be;
          end else begin
            r_byte_tmr <= r_byte_tmr + c_BT_W'(1);
          end
        end
        default: r_byte_tmr <= '0;
      endcase
    end
  end

  // Read response timer, running only while waiting for valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_resp_tmr <= '0;
    else if (r_state == ST_WAIT_RD) r_resp_tmr <= r_resp_tmr + c_RT_W'(1);
    else                            r_resp_tmr <= '0;
  end

  uart_bus_master_resp_ser u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_ser_start),
    .i_count    (w_ser_count),
    .i_bytes    (w_ser_bytes),
    .i_tx_ready (tx_ready),
    .o_tx_data  (tx_data),
    .o_tx_we    (tx_we),
    .o_done     (w_ser_done)
  );

  assign bus_req = (r_state == ST_ISSUE) || (r_state == ST_WAIT_RD);
  assign busy    = (r_state != ST_IDLE);
  assign addr    = r_addr;
  assign wdata   = r_wdata;
  assign we      = r_we;

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_bus_master                                              |
// | Brief    : Directed self-checking bench for uart_bus_master                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_uart_bus_master;

  localparam int MS = 27;
  localparam int BT = 50;
  localparam int RT = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_we;
  logic          tx_ready;
  logic          bus_req;
  logic          bus_gnt;
  logic [3:0]    oe;
  logic [MS-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    we;
  logic [31:0]   rdata;
  logic          valid;
  logic          busy;

  int errors = 0;
  int checks = 0;

  uart_bus_master #(.MEM_SCALE(MS), .BYTE_TIMEOUT(BT), .RESP_TIMEOUT(RT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_we(tx_we), .tx_ready(tx_ready),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .oe(oe), .addr(addr), .wdata(wdata),
    .we(we), .rdata(rdata), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle counter and a UART TX model that drops READY for 3 cycles after WE
  int   cyc = 0;
  int   tx_busy = 0;
  logic tx_ready_en;
  assign tx_ready = tx_ready_en && (tx_busy == 0);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_we === 1'b1) tx_busy <= 3;
    else if (tx_busy > 0) tx_busy <= tx_busy - 1;
  end

  // Bus/UART observer, sampling on the falling edge
  int          oe_count = 0;
  int          oe_cyc = -1;
  logic [3:0]  cap_oe;
  logic [MS-1:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_we;
  logic [7:0]  tx_q[$];
  int          tx_cyc = -1;
  int          viol = 0;
  int          breq_last = -1;
  int          last_rx = -1;
  always @(negedge clk) begin
    if (oe !== 4'h0) begin
      oe_count  <= oe_count + 1;
      oe_cyc    <= cyc;
      cap_oe    <= oe;
      cap_addr  <= addr;
      cap_wdata <= wdata;
      cap_we    <= we;
    end
    if (tx_we === 1'b1) begin
      tx_q.push_back(tx_data);
      tx_cyc <= cyc;
      if (tx_ready !== 1'b1) viol <= viol + 1;
    end
    if (bus_req === 1'b1) breq_last <= cyc;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    last_rx  = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (tx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Waits for the strobe, then returns read data d cycles after it
  task automatic respond(input int d, input logic [31:0] data, output bit ok);
    ok = 1'b0;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (oe === 4'hF) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      repeat (d) @(posedge clk);
      #1;
      rdata = data;
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] tx_word();
    if (tx_q.size() >= 4) return {tx_q[0], tx_q[1], tx_q[2], tx_q[3]};
    return 32'hxxxxxxxx;
  endfunction

  task automatic test_reset();
    #3;
    checks++; if (tx_we !== 1'b0)   begin errors++; $display("FAIL reset_tx_we: got %b want 0", tx_we); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
    checks++; if (oe !== 4'h0)      begin errors++; $display("FAIL reset_oe: got %h want 0", oe); end
    checks++; if (we !== 4'h0)      begin errors++; $display("FAIL reset_we: got %h want 0", we); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (tx_data !== 8'h0) begin errors++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
    checks++; if (addr !== '0)      begin errors++; $display("FAIL reset_addr: got %h want 0", addr); end
    checks++; if (wdata !== 32'h0)  begin errors++; $display("FAIL reset_wdata: got %h want 0", wdata); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write();
    bit ok;
    int oc0 = oe_count;
    logic [7:0] f[9] = '{8'hA5, 8'h00, 8'h00, 8'hFF, 8'h18, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    tx_q.delete();
    bus_gnt = 1'b1;
    foreach (f[i]) send_byte(f[i]);
    wait_tx(1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_ack_timeout: got %0d bytes want 1", tx_q.size()); end
    checks++; if (oe_count - oc0 !== 1) begin errors++; $display("FAIL write_oe_count: got %0d want 1", oe_count - oc0); end
    checks++; if (cap_oe !== 4'hF) begin errors++; $display("FAIL write_oe_val: got %h want f", cap_oe); end
    checks++; if (oe_cyc !== last_rx + 1) begin errors++; $display("FAIL write_oe_cycle: got %0d want %0d", oe_cyc, last_rx + 1); end
    checks++; if (cap_addr !== 27'h000FF18) begin errors++; $display("FAIL write_addr: got %h want 000ff18", cap_addr); end
    checks++; if (cap_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL write_wdata: got %h want deadbeef", cap_wdata); end
    checks++; if (cap_we !== 4'h5) begin errors++; $display("FAIL write_we: got %h want 5", cap_we); end
    checks++; if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin errors++; $display("FAIL write_reply: got %0d bytes first %h want 1 byte 4b", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
    checks++; if (tx_cyc - last_rx < 2) begin errors++; $display("FAIL write_latency: got %0d want >=2", tx_cyc - last_rx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_read();
    bit ok, rok;
    int oc0 = oe_count;
    logic [7:0] f[5] = '{8'h52, 8'h00, 8'h00, 8'hFF, 8'h14};
    tx_q.delete();
    foreach (f[i]) send_byte(f[i]);
    respond(3, 32'h12345678, rok);
    wait_tx(4, 100, ok);
    checks++; if (!(rok && ok)) begin errors++; $display("FAIL read_timeout: got oe=%0b bytes=%0d want strobe and 4 bytes", rok, tx_q.size()); end
    checks++; if (oe_count - oc0 !== 1) begin errors++; $display("FAIL read_oe_count: got %0d want 1", oe_count - oc0); end
    checks++; if (cap_addr !== 27'h000FF14) begin errors++; $display("FAIL read_addr: got %h want 000ff14", cap_addr); end
    checks++; if (cap_we !== 4'h0) begin errors++; $display("FAIL read_we: got %h want 0", cap_we); end
    checks++; if (tx_word() !== 32'h12345678) begin errors++; $display("FAIL read_data: got %h want 12345678", tx_word()); end
    checks++; if (bus_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL read_end: got req=%b busy=%b want 0 0", bus_req, busy); end
  endtask

  task automatic test_read_timeout();
    bit ok;
    logic [7:0] f[5] = '{8'h52, 8'hFF, 8'h00, 8'h00, 8'h04};
    tx_q.delete();
    foreach (f[i]) send_byte(f[i]);
    wait_tx(1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rto_no_reply: got %0d bytes want 1", tx_q.size()); end
    checks++; if (cap_addr !== 27'h7000004) begin errors++; $display("FAIL rto_addr_trunc: got %h want 7000004", cap_addr); end
    checks++; if (tx_q.size() !== 1 || tx_q[0] !== 8'hEE) begin errors++; $display("FAIL rto_reply: got %0d bytes first %h want 1 byte ee", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
    checks++; if (breq_last - oe_cyc !== RT) begin errors++; $display("FAIL rto_wait_len: got %0d want %0d", breq_last - oe_cyc, RT); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rto_bus_req: got %b want 0", bus_req); end
  endtask

  task automatic test_valid_at_timeout();
    bit ok, rok;
    logic [7:0] f[5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h40};
    tx_q.delete();
    foreach (f[i]) send_byte(f[i]);
    respond(RT, 32'hA1B2C3D4, rok);
    wait_tx(4, 100, ok);
    checks++; if (!(rok && ok)) begin errors++; $display("FAIL vto_handshake: got oe=%0b bytes=%0d want strobe and 4 bytes", rok, tx_q.size()); end
    checks++; if (tx_q.size() !== 4 || tx_word() !== 32'hA1B2C3D4) begin errors++; $display("FAIL vto_data_wins: got %0d bytes %h want 4 bytes a1b2c3d4", tx_q.size(), tx_word()); end
  endtask

  task automatic test_bad_cmd();
    bit ok;
    int oc0 = oe_count;
    tx_q.delete();
    send_byte(8'h00);
    wait_tx(1, 50, ok);
    checks++; if (!ok || tx_q[0] !== 8'h3F) begin errors++; $display("FAIL badcmd_reply: got %0d bytes first %h want 3f", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
    checks++; if (oe_count !== oc0) begin errors++; $display("FAIL badcmd_oe: got %0d strobes want 0", oe_count - oc0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badcmd_busy: got %b want 0", busy); end
  endtask

  task automatic test_gnt_low();
    bit ok, rok;
    int oc0 = oe_count;
    int gcyc;
    logic [7:0] f[5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
    tx_q.delete();
    bus_gnt = 1'b0;
    foreach (f[i]) send_byte(f[i]);
    repeat (50) @(posedge clk);
    #1;
    checks++; if (oe_count !== oc0) begin errors++; $display("FAIL gnt_low_oe: got %0d strobes want 0", oe_count - oc0); end
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL gnt_low_req: got %b want 1", bus_req); end
    bus_gnt = 1'b1;
    gcyc = cyc;
    respond(3, 32'h0BADF00D, rok);
    wait_tx(4, 100, ok);
    checks++; if (oe_cyc !== gcyc || oe_count - oc0 !== 1) begin errors++; $display("FAIL gnt_first_cycle: got cycle %0d count %0d want cycle %0d count 1", oe_cyc, oe_count - oc0, gcyc); end
    checks++; if (tx_word() !== 32'h0BADF00D) begin errors++; $display("FAIL gnt_read_data: got %h want 0badf00d", tx_word()); end
  endtask

  task automatic test_byte_timeout();
    bit ok;
    logic [7:0] f[9] = '{8'hA3, 8'h00, 8'h00, 8'h00, 8'h20, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    tx_q.delete();
    send_byte(8'h52);
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (BT / 2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bto_busy_mid: got %b want 1", busy); end
    repeat (BT) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || tx_q.size() !== 0) begin errors++; $display("FAIL bto_drop: got busy=%b bytes=%0d want 0 0", busy, tx_q.size()); end
    foreach (f[i]) send_byte(f[i]);
    wait_tx(1, 100, ok);
    checks++; if (cap_addr !== 27'h20 || cap_wdata !== 32'hCAFEBABE || cap_we !== 4'h3) begin errors++; $display("FAIL bto_next_frame: got addr=%h wdata=%h we=%h want 20 cafebabe 3", cap_addr, cap_wdata, cap_we); end
    checks++; if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin errors++; $display("FAIL bto_next_ack: got %0d bytes want 1 byte 4b", tx_q.size()); end
  endtask

  task automatic test_tx_ready_low();
    bit ok, rok;
    logic [7:0] f[5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h0C};
    tx_q.delete();
    tx_ready_en = 1'b0;
    foreach (f[i]) send_byte(f[i]);
    respond(3, 32'h89ABCDEF, rok);
    repeat (30) @(posedge clk);
    #1;
    checks++; if (tx_q.size() !== 0 || busy !== 1'b1) begin errors++; $display("FAIL txr_held: got bytes=%0d busy=%b want 0 1", tx_q.size(), busy); end
    send_byte(8'h00);
    tx_ready_en = 1'b1;
    wait_tx(4, 200, ok);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (!rok || tx_q.size() !== 4 || tx_word() !== 32'h89ABCDEF) begin errors++; $display("FAIL txr_bytes: got %0d bytes %h want 4 bytes 89abcdef", tx_q.size(), tx_word()); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL txr_we_not_ready: got %0d strobes want 0", viol); end
  endtask

  task automatic test_reset_mid();
    bit rok;
    logic [7:0] f[5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h10};
    tx_q.delete();
    foreach (f[i]) send_byte(f[i]);
    respond(5, 32'h0, rok);
    checks++; if (!rok) begin errors++; $display("FAIL rmid_no_strobe: got none want one"); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0 || busy !== 1'b0 || oe !== 4'h0 || addr !== '0) begin errors++; $display("FAIL rmid_async: got req=%b busy=%b oe=%h addr=%h want all 0", bus_req, busy, oe, addr); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rdata = 32'hFFFFFFFF;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (tx_q.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_ignore_valid: got bytes=%0d busy=%b want 0 0", tx_q.size(), busy); end
  endtask

  initial begin
    rst_n       = 1'b0;
    rx_data     = 8'h0;
    rx_valid    = 1'b0;
    bus_gnt     = 1'b0;
    rdata       = 32'h0;
    valid       = 1'b0;
    tx_ready_en = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_read_timeout();
    test_valid_at_timeout();
    test_bad_cmd();
    test_gnt_low();
    test_byte_timeout();
    test_tx_ready_low();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
